// File: rtl/eq_pkg.sv
// Shared equalizer definitions: coefficient layout, bank FSM states and sizing helpers.
package eq_pkg;

   localparam int unsigned NR_EQ_BAND_COEFF    = 5;
   localparam int unsigned NR_EQ_BANDS_DEFAULT = 8;

   typedef enum logic [2:0] {
      A0 = 3'd0,
      A1 = 3'd1,
      A2 = 3'd2,
      B1 = 3'd3,
      B2 = 3'd4
   } coeff_k_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      COPY    = 2'd2
   } bank_state_e;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r = 0;
      while ((64'd1 << r) < 64'(n)) r++;
      return r;
   endfunction

   function automatic int unsigned coeff_index(input int unsigned ch,
                                               input int unsigned band,
                                               input coeff_k_e    k,
                                               input int unsigned nr_bands = NR_EQ_BANDS_DEFAULT);
      return (ch * nr_bands + band) * NR_EQ_BAND_COEFF + 32'(k);
   endfunction

   // Unity gain in signed Q4.(w-4).
   function automatic logic [63:0] coeff_one(input int unsigned w);
      return 64'd1 << (w - 4);
   endfunction

endpackage

// File: rtl/equalizer_coeff_bank_if.sv
// Host configuration and equalizer-side signals of the coefficient bank.
// cfg_rd_data is present only when COEFF_BANK_READBACK_EN is defined.
interface equalizer_coeff_bank_if #(
   parameter int unsigned AW = 8,
   parameter int unsigned W  = 32,
   parameter int unsigned CW = 2
);

   logic [AW-1:0] cfg_addr;
   logic [W-1:0]  cfg_data;
   logic          cfg_valid;
   logic          cfg_ready;
   logic          cfg_commit;
   logic          cfg_busy;
   logic          active_bank;
   logic [AW-1:0] eq_coeff_addr;
   logic [W-1:0]  eq_coeff;
   logic          eq_s_tvalid;
   logic          eq_s_tready;
   logic [CW-1:0] eq_s_tid;
`ifdef COEFF_BANK_READBACK_EN
   logic [W-1:0]  cfg_rd_data;
`endif

   modport master (
      output cfg_addr, cfg_data, cfg_valid, cfg_commit,
      output eq_coeff_addr, eq_s_tvalid, eq_s_tready, eq_s_tid,
`ifdef COEFF_BANK_READBACK_EN
      input  cfg_rd_data,
`endif
      input  cfg_ready, cfg_busy, active_bank, eq_coeff
   );

   modport slave (
      input  cfg_addr, cfg_data, cfg_valid, cfg_commit,
      input  eq_coeff_addr, eq_s_tvalid, eq_s_tready, eq_s_tid,
`ifdef COEFF_BANK_READBACK_EN
      output cfg_rd_data,
`endif
      output cfg_ready, cfg_busy, active_bank, eq_coeff
   );

endinterface

// File: rtl/coeff_dpram.sv
// Two-bank distributed coefficient RAM: one write port, async reads for the equalizer,
// the bank copy and (COEFF_BANK_READBACK_EN) host readback of the shadow bank.
module coeff_dpram
   import eq_pkg::*;
#(
   parameter int unsigned DEPTH = 160,
   parameter int unsigned W     = 32,
   parameter int unsigned AW    = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic          wr_bank,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
   input  logic          eq_bank,
   input  logic [AW-1:0] eq_addr,
   output logic [W-1:0]  eq_data,
   input  logic          cp_bank,
   input  logic [AW-1:0] cp_addr,
   output logic [W-1:0]  cp_data
`ifdef COEFF_BANK_READBACK_EN
   ,
   input  logic          rb_bank,
   input  logic [AW-1:0] rb_addr,
   output logic [W-1:0]  rb_data
`endif
);

   localparam logic [W-1:0] ONE = W'(coeff_one(W));

   // Words are held XORed with the passthrough image, so the all-zero power-up
   // contents of both banks read back as passthrough without any reset clearing.
   logic [W-1:0] mem [2][DEPTH] = '{default: '0};

   function automatic logic [W-1:0] pass_word(input logic [AW-1:0] a);
      return ((32'(a) % NR_EQ_BAND_COEFF) == 32'd0) ? ONE : '0;
   endfunction

   always_ff @(posedge clk) begin
      if (we && (32'(wr_addr) < DEPTH)) mem[wr_bank][wr_addr] <= wr_data ^ pass_word(wr_addr);
   end

   assign eq_data = (32'(eq_addr) < DEPTH) ? (mem[eq_bank][eq_addr] ^ pass_word(eq_addr)) : '0;
   assign cp_data = (32'(cp_addr) < DEPTH) ? (mem[cp_bank][cp_addr] ^ pass_word(cp_addr)) : '0;

`ifdef COEFF_BANK_READBACK_EN
   assign rb_data = (32'(rb_addr) < DEPTH) ? (mem[rb_bank][rb_addr] ^ pass_word(rb_addr)) : '0;
`endif

endmodule

// File: rtl/equalizer_coeff_bank.sv
// Double-buffered biquad coefficient store feeding the equalizer coefficient port.
// Optional shadow-bank readback on cfg_rd_data: define COEFF_BANK_READBACK_EN.
module equalizer_coeff_bank
   import eq_pkg::*;
#(
   parameter int unsigned NR_CHANNELS    = 4,
   parameter int unsigned NR_EQ_BANDS    = 8,
   parameter int unsigned EQ_COEFF_WIDTH = 32
) (
   input logic                   clk,
   input logic                   rst_n,
   equalizer_coeff_bank_if.slave bus
);

   localparam int unsigned NR_EQ_COEFF = NR_CHANNELS * NR_EQ_BANDS * NR_EQ_BAND_COEFF;
   localparam int unsigned AW          = clog2(NR_EQ_COEFF);
   localparam int unsigned CW          = clog2(NR_CHANNELS);
   localparam int unsigned W           = EQ_COEFF_WIDTH;
   localparam logic [AW-1:0] LAST      = AW'(NR_EQ_COEFF - 1);

   bank_state_e   state, state_next;
   logic          bank, bank_next;
   logic [AW-1:0] cnt, cnt_next;
   logic          ready, ready_next;
   logic          busy, busy_next;
   logic          swap;
   logic          we;
   logic [AW-1:0] wr_addr;
   logic [W-1:0]  wr_data;
   logic [W-1:0]  cp_data;

   // Frame start: channel-0 sample accepted by the equalizer.
   assign swap = bus.eq_s_tvalid && bus.eq_s_tready && (bus.eq_s_tid == CW'(0));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         bank  <= 1'b0;
         cnt   <= '0;
         ready <= 1'b1;
         busy  <= 1'b0;
      end else begin
         state <= state_next;
         bank  <= bank_next;
         cnt   <= cnt_next;
         ready <= ready_next;
         busy  <= busy_next;
      end
   end

   always_comb begin
      state_next = state;
      bank_next  = bank;
      cnt_next   = cnt;
      case (state)
         IDLE: begin
            if (bus.cfg_commit) state_next = PENDING;
         end
         PENDING: begin
            if (swap) begin
               bank_next  = ~bank;
               cnt_next   = '0;
               state_next = COPY;
            end
         end
         COPY: begin
            cnt_next = cnt + AW'(1);
            if (cnt == LAST) begin
               cnt_next   = '0;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Shadow write source: host in IDLE, refresh from the new active bank in COPY.
   always_comb begin
      we         = 1'b0;
      wr_addr    = bus.cfg_addr;
      wr_data    = bus.cfg_data;
      ready_next = (state_next == IDLE);
      busy_next  = (state_next != IDLE);
      case (state)
         IDLE: we = bus.cfg_valid;
         COPY: begin
            we      = 1'b1;
            wr_addr = cnt;
            wr_data = cp_data;
         end
         default: we = 1'b0;
      endcase
   end

   coeff_dpram #(
      .DEPTH (NR_EQ_COEFF),
      .W     (W),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .we      (we),
      .wr_bank (~bank),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .eq_bank (bank),
      .eq_addr (bus.eq_coeff_addr),
      .eq_data (bus.eq_coeff),
      .cp_bank (bank),
      .cp_addr (cnt),
      .cp_data (cp_data)
`ifdef COEFF_BANK_READBACK_EN
      ,
      .rb_bank (~bank),
      .rb_addr (bus.cfg_addr),
      .rb_data (bus.cfg_rd_data)
`endif
   );

   assign bus.cfg_ready   = ready;
   assign bus.cfg_busy    = busy;
   assign bus.active_bank = bank;

endmodule

// File: tb/tb_equalizer_coeff_bank.sv
// Directed bench for equalizer_coeff_bank: bank swap on frame start, shadow refresh,
// hold without audio, same-cycle write/commit and reset during the copy.
module tb_equalizer_coeff_bank;
   import eq_pkg::*;

   localparam int unsigned N  = 160;
   localparam int unsigned AW = 8;
   localparam int unsigned W  = 32;
   localparam int unsigned CW = 2;
   localparam logic [31:0] ONE = 32'h1000_0000;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   equalizer_coeff_bank_if #(.AW(AW), .W(W), .CW(CW)) bus ();

   equalizer_coeff_bank #(
      .NR_CHANNELS    (4),
      .NR_EQ_BANDS    (8),
      .EQ_COEFF_WIDTH (32)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   logic [31:0] act_m  [N];
   logic [31:0] shd_m  [N];
   logic [31:0] prev_m [N];
   int unsigned cyc;
   int unsigned nb;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic host_write(input logic [AW-1:0] a, input logic [31:0] d, input logic commit);
      bus.cfg_addr   = a;
      bus.cfg_data   = d;
      bus.cfg_valid  = 1'b1;
      bus.cfg_commit = commit;
      tick();
      bus.cfg_valid  = 1'b0;
      bus.cfg_commit = 1'b0;
      if (32'(a) < N) shd_m[a] = d;
   endtask

   task automatic pulse_commit();
      bus.cfg_commit = 1'b1;
      tick();
      bus.cfg_commit = 1'b0;
   endtask

   task automatic snoop(input logic [CW-1:0] tid, input logic v, input logic r);
      bus.eq_s_tid    = tid;
      bus.eq_s_tvalid = v;
      bus.eq_s_tready = r;
      tick();
      bus.eq_s_tvalid = 1'b0;
      bus.eq_s_tready = 1'b0;
      bus.eq_s_tid    = '0;
   endtask

   task automatic wait_idle(output int unsigned n);
      n = 0;
      while (bus.cfg_busy && n < 400) begin
         tick();
         n++;
      end
   endtask

   task automatic scan(input string tag);
      for (int unsigned a = 0; a < N; a++) begin
         bus.eq_coeff_addr = AW'(a);
         @(negedge clk);
         check($sformatf("%s[%0d]", tag, a), bus.eq_coeff, act_m[a]);
      end
   endtask

   task automatic check_status(input string tag, input logic bank, input logic ready, input logic busy);
      check({tag, "_bank"},  32'(bus.active_bank), 32'(bank));
      check({tag, "_ready"}, 32'(bus.cfg_ready),   32'(ready));
      check({tag, "_busy"},  32'(bus.cfg_busy),    32'(busy));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.cfg_addr      = '0;
      bus.cfg_data      = '0;
      bus.cfg_valid     = 1'b0;
      bus.cfg_commit    = 1'b0;
      bus.eq_coeff_addr = '0;
      bus.eq_s_tvalid   = 1'b0;
      bus.eq_s_tready   = 1'b0;
      bus.eq_s_tid      = '0;
      rst_n             = 1'b0;

      for (int unsigned i = 0; i < N; i++) act_m[i] = '0;
      for (int unsigned ch = 0; ch < 4; ch++)
         for (int unsigned b = 0; b < 8; b++) act_m[coeff_index(ch, b, A0)] = ONE;
      shd_m = act_m;

      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // Power-up: passthrough in the active bank
      check_status("rst", 1'b0, 1'b1, 1'b0);
      scan("rst_scan");

      // Shadow write is invisible until the swap
      host_write(8'd5, 32'hF000_0000, 1'b0);
      bus.eq_coeff_addr = 8'd5;
      #1;
      check("pre_commit_a5", bus.eq_coeff, ONE);
      pulse_commit();
      check_status("pend1", 1'b0, 1'b0, 1'b1);
      check("pend1_a5", bus.eq_coeff, ONE);
      snoop(2'd0, 1'b1, 1'b1);
      act_m = shd_m;
      check("swap1_bank", 32'(bus.active_bank), 32'd1);
      check("swap1_a5", bus.eq_coeff, 32'hF000_0000);
      wait_idle(cyc);
      check("copy1_len", cyc, 32'd160);
      check_status("idle1", 1'b1, 1'b1, 1'b0);
      scan("swap1_scan");

      // No audio: stays pending; writes, commits and non-accepts are ignored
      pulse_commit();
      nb = 0;
      bus.cfg_addr = '0;
      bus.cfg_data = 32'hDEAD_BEEF;
      for (int unsigned i = 0; i < 1000; i++) begin
         bus.cfg_valid   = (i == 10);
         bus.cfg_commit  = (i == 20);
         bus.eq_s_tvalid = (i == 30);
         bus.eq_s_tready = (i == 31);
         tick();
         if (bus.cfg_busy === 1'b1 && bus.cfg_ready === 1'b0 && bus.active_bank === 1'b1) nb++;
      end
      bus.cfg_valid   = 1'b0;
      bus.cfg_commit  = 1'b0;
      bus.eq_s_tvalid = 1'b0;
      bus.eq_s_tready = 1'b0;
      check("no_audio_hold", nb, 32'd1000);
      snoop(2'd2, 1'b1, 1'b1);
      check_status("tid2", 1'b1, 1'b0, 1'b1);
      snoop(2'd0, 1'b1, 1'b1);
      act_m = shd_m;
      check("swap2_bank", 32'(bus.active_bank), 32'd0);
      wait_idle(cyc);
      check("copy2_len", cyc, 32'd160);

      // Partial update: only addr 10 changes, the rest carries over from the copy
      host_write(8'd10, 32'h1234_5678, 1'b0);
`ifdef COEFF_BANK_READBACK_EN
      bus.cfg_addr = 8'd10;
      #1;
      check("rb_a10", bus.cfg_rd_data, 32'h1234_5678);
      bus.cfg_addr = 8'd200;
      #1;
      check("rb_oob", bus.cfg_rd_data, 32'h0);
`endif
      pulse_commit();
      snoop(2'd0, 1'b1, 1'b1);
      act_m = shd_m;
      check("swap3_bank", 32'(bus.active_bank), 32'd1);
      wait_idle(cyc);
      check("copy3_len", cyc, 32'd160);
      scan("partial_scan");

      // Out-of-range write accepted and dropped; write + commit in the same cycle
      host_write(8'd170, 32'h5555_5555, 1'b0);
      check("oob_ready", 32'(bus.cfg_ready), 32'd1);
      host_write(8'd159, 32'hABCD_0001, 1'b1);
      check_status("wc_pend", 1'b1, 1'b0, 1'b1);
      snoop(2'd0, 1'b1, 1'b1);
      act_m = shd_m;
      bus.eq_coeff_addr = 8'd159;
      #1;
      check("wc_a159", bus.eq_coeff, 32'hABCD_0001);
      check("wc_bank", 32'(bus.active_bank), 32'd0);
      bus.eq_coeff_addr = 8'd200;
      #1;
      check("oob_200", bus.eq_coeff, 32'h0);
      bus.eq_coeff_addr = 8'd255;
      #1;
      check("oob_255", bus.eq_coeff, 32'h0);
      wait_idle(cyc);
      check("copy4_len", cyc, 32'd160);

      // Reset in the middle of the copy
      prev_m = act_m;
      pulse_commit();
      snoop(2'd0, 1'b1, 1'b1);
      check("swap5_bank", 32'(bus.active_bank), 32'd1);
      repeat (50) tick();
      check("copy5_busy", 32'(bus.cfg_busy), 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_status("copy_rst", 1'b0, 1'b1, 1'b0);
      act_m = prev_m;
      bus.eq_coeff_addr = 8'd159;
      #1;
      check("rst_keeps_a159", bus.eq_coeff, 32'hABCD_0001);
      bus.eq_coeff_addr = 8'd5;
      #1;
      check("rst_keeps_a5", bus.eq_coeff, 32'hF000_0000);
      tick();
      check_status("post_rst", 1'b0, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
